// File: rtl/mhsa_pkg.sv
// mhsa_pkg: shared state type and usram geometry for the MHSA job scheduler
package mhsa_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} sched_state_t;
   localparam int USRAM_AW = 14;
   localparam int USRAM_DW = 64;
endpackage

// File: rtl/usram_rd_skid.sv
// usram_rd_skid: 2-entry synchronous FIFO holding usram read data for the engine
//  clk, rst_n : clock, synchronous active-low reset (flushes the FIFO)
//  push_i     : write data_i this cycle
//  pop_i      : drop the head entry this cycle
//  data_o     : head entry
//  count_o    : occupancy 0..2
module usram_rd_skid import mhsa_pkg::*; (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push_i,
   input  logic                pop_i,
   input  logic [USRAM_DW-1:0] data_i,
   output logic [USRAM_DW-1:0] data_o,
   output logic [1:0]          count_o
);
   logic [USRAM_DW-1:0] mem_q [2];
   logic                wr_ptr_q, rd_ptr_q;
   logic [1:0]          count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_i) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + 2'(push_i) - 2'(pop_i);
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
endmodule

// File: rtl/usram_job_sched.sv
// usram_job_sched: sequences one MHSA load/store job and owns the shared usram port
//  clk, rst_n                : clock, synchronous active-low reset
//  start_i                   : rising edge launches a job (ignored while busy)
//  input_base_i, len_in_i    : load phase address and word count
//  output_base_i, len_out_i  : store phase address and word count
//  busy_o, done_o            : job in progress / one-cycle completion pulse
//  host_*                    : host usram access, granted only while idle
//  usram_*                   : usram port (read data valid one cycle after a read)
//  eng_in_*                  : load stream to the engine (valid/ready)
//  eng_out_*                 : result stream from the engine (valid/ready)
module usram_job_sched import mhsa_pkg::*; #(
   parameter int AW = USRAM_AW,
   parameter int LW = 14
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic [AW-1:0]       input_base_i,
   input  logic [AW-1:0]       output_base_i,
   input  logic [LW-1:0]       len_in_i,
   input  logic [LW-1:0]       len_out_i,
   output logic                busy_o,
   output logic                done_o,
   input  logic                host_req_i,
   input  logic                host_we_i,
   input  logic [AW-1:0]       host_addr_i,
   input  logic [USRAM_DW-1:0] host_wdata_i,
   output logic                host_gnt_o,
   output logic                usram_en_o,
   output logic                usram_we_o,
   output logic [AW-1:0]       usram_addr_o,
   output logic [USRAM_DW-1:0] usram_wdata_o,
   input  logic [USRAM_DW-1:0] usram_rdata_i,
   output logic                eng_in_valid_o,
   input  logic                eng_in_ready_i,
   output logic [USRAM_DW-1:0] eng_in_data_o,
   input  logic                eng_out_valid_i,
   output logic                eng_out_ready_o,
   input  logic [USRAM_DW-1:0] eng_out_data_i
);
   sched_state_t        state_q, state_d;
   logic                start_q, inflight_q;
   logic [AW-1:0]       in_base_q, in_base_d, out_base_q, out_base_d;
   logic [LW-1:0]       len_in_q, len_in_d, len_out_q, len_out_d;
   logic [LW-1:0]       rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
   logic [USRAM_DW-1:0] wdata_q;
   logic [1:0]          skid_cnt;
   logic                launch, pop, rd_issue, wr_beat, host_wr;

   usram_rd_skid u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (inflight_q),
      .pop_i   (pop),
      .data_i  (usram_rdata_i),
      .data_o  (eng_in_data_o),
      .count_o (skid_cnt)
   );

   assign launch         = start_i & ~start_q & (state_q == IDLE);
   assign eng_in_valid_o = skid_cnt != 2'd0;
   assign pop            = eng_in_valid_o & eng_in_ready_i;
   // A slot freed by this cycle's pop counts as credit, so an always-ready engine gets 1 word/cycle
   assign rd_issue       = (state_q == LOAD) && (rd_cnt_q < len_in_q) &&
                           ((3'(skid_cnt) + 3'(inflight_q)) < (3'd2 + 3'(pop)));
   // Ready is withheld once len_out beats are taken so len_out=0 never writes
   assign eng_out_ready_o = (state_q == STORE) && (wr_cnt_q < len_out_q);
   assign wr_beat         = eng_out_ready_o & eng_out_valid_i;
   assign host_gnt_o      = (state_q == IDLE) & host_req_i;
   assign host_wr         = host_gnt_o & host_we_i;
   assign usram_en_o      = host_gnt_o | rd_issue | wr_beat;
   assign usram_we_o      = host_wr | wr_beat;
   assign usram_addr_o    = state_q == LOAD  ? in_base_q + AW'(rd_cnt_q) :
                            state_q == STORE ? out_base_q + AW'(wr_cnt_q) : host_addr_i;
   assign usram_wdata_o   = wr_beat ? eng_out_data_i : host_wr ? host_wdata_i : wdata_q;
   assign busy_o          = state_q != IDLE;
   assign done_o          = state_q == DONE;

   always_comb begin
      state_d    = state_q;
      in_base_d  = in_base_q;
      out_base_d = out_base_q;
      len_in_d   = len_in_q;
      len_out_d  = len_out_q;
      rd_cnt_d   = rd_cnt_q + LW'(rd_issue);
      wr_cnt_d   = wr_cnt_q + LW'(wr_beat);
      case (state_q)
         IDLE: if (launch) begin
            state_d    = LOAD;
            in_base_d  = input_base_i;
            out_base_d = output_base_i;
            len_in_d   = len_in_i;
            len_out_d  = len_out_i;
            rd_cnt_d   = '0;
            wr_cnt_d   = '0;
         end
         LOAD:    if (rd_cnt_q == len_in_q && skid_cnt == 2'd0 && !inflight_q) state_d = STORE;
         STORE:   if (wr_cnt_q == len_out_q) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         start_q    <= 1'b1;
         inflight_q <= 1'b0;
         in_base_q  <= '0;
         out_base_q <= '0;
         len_in_q   <= '0;
         len_out_q  <= '0;
         rd_cnt_q   <= '0;
         wr_cnt_q   <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         start_q    <= start_i;
         inflight_q <= rd_issue;
         in_base_q  <= in_base_d;
         out_base_q <= out_base_d;
         len_in_q   <= len_in_d;
         len_out_q  <= len_out_d;
         rd_cnt_q   <= rd_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
         wdata_q    <= usram_wdata_o;
      end
   end
endmodule
